// File: rtl/board_io_pkg.sv
// board_io_pkg -- shared encodings and helpers for the board I/O front end.
//   EVT_RISE/EVT_FALL/EVT_BOTH : encodings for the EVT_MODE parameter.
//   deb_cnt_w()                : debounce counter width for a given stable-cycle count.
`timescale 1ns/1ps
package board_io_pkg;

  localparam int EVT_RISE = 0;
  localparam int EVT_FALL = 1;
  localparam int EVT_BOTH = 2;

  // Width able to hold 0..cycles; never below 1 bit.
  function automatic int deb_cnt_w(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/board_io_frontend_debounce.sv
// io_debounce -- one input channel: 2-FF synchronizer, counter debouncer and
// registered rise/fall pulses aligned with the stable-level update.
// Ports:
//   clk_i, arst_n_i : clock, async active-low reset
//   raw_i           : raw asynchronous pin
//   stable_o        : debounced level
//   rise_o, fall_o  : 1-cycle pulses in the first cycle stable_o shows the new level
`timescale 1ns/1ps
module io_debounce
  import board_io_pkg::*;
#(
  parameter int DEB_CYCLES = 50000
) (
  input  logic clk_i,
  input  logic arst_n_i,
  input  logic raw_i,
  output logic stable_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int              CW       = deb_cnt_w(DEB_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          stable_q, rise_q, fall_q;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw_i};
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (sync_q[1] == stable_q) begin
        // Any return to the accepted level restarts the qualification window.
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        stable_q <= sync_q[1];
        cnt_q    <= '0;
        rise_q   <= sync_q[1];
        fall_q   <= ~sync_q[1];
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;

endmodule

// File: rtl/board_io_frontend.sv
// board_io_frontend -- conditioning between raw board pins and the GPIO bus.
// Inputs are synchronized, debounced, edge-detected and latched into sticky
// event flags; LED outputs are registered and optionally PWM-dimmed.
// Optional feature macro: BOARD_IO_PWM_EN (global PWM brightness). Without it
// led_duty_i is ignored and led_o is simply led_val_i delayed one cycle.
// Ports:
//   clk_i, arst_n_i : clock, async active-low reset
//   in_raw_i        : raw pin inputs (IN_CH)
//   in_stable_o     : debounced levels
//   in_rise_o/in_fall_o : 1-cycle edge pulses on debounced levels
//   event_o         : sticky edge flags (source selected by EVT_MODE)
//   event_clr_i     : per-bit clear of event_o (a same-cycle set wins)
//   led_val_i       : LED on/off request (OUT_CH)
//   led_duty_i      : global brightness duty (PWM_W)
//   led_o           : registered LED pin drive
`timescale 1ns/1ps
module board_io_frontend
  import board_io_pkg::*;
#(
  parameter int IN_CH      = 12,
  parameter int OUT_CH     = 8,
  parameter int DEB_CYCLES = 50000,
  parameter int EVT_MODE   = 0,
  parameter int PWM_W      = 8,
  parameter int PRESCALE   = 16
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic [IN_CH-1:0]  in_raw_i,
  output logic [IN_CH-1:0]  in_stable_o,
  output logic [IN_CH-1:0]  in_rise_o,
  output logic [IN_CH-1:0]  in_fall_o,
  output logic [IN_CH-1:0]  event_o,
  input  logic [IN_CH-1:0]  event_clr_i,
  input  logic [OUT_CH-1:0] led_val_i,
  input  logic [PWM_W-1:0]  led_duty_i,
  output logic [OUT_CH-1:0] led_o
);

  // ---------------- input channels ----------------
  logic [IN_CH-1:0] stable, rise, fall;

  for (genvar g = 0; g < IN_CH; g++) begin : g_ch
    io_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk_i    (clk_i),
      .arst_n_i (arst_n_i),
      .raw_i    (in_raw_i[g]),
      .stable_o (stable[g]),
      .rise_o   (rise[g]),
      .fall_o   (fall[g])
    );
  end

  assign in_stable_o = stable;
  assign in_rise_o   = rise;
  assign in_fall_o   = fall;

  // ---------------- sticky events ----------------
  // rise/fall are already registered, so the flag sets on the edge after the
  // pulse appears... except we want the same cycle: use the pulse sources'
  // next-state equivalent by registering on the same edge via the pulse itself
  // one cycle later would lag. Instead the flag is OR-ed combinationally with
  // the current pulse, so event_o shows the event in the pulse cycle.
  logic [IN_CH-1:0] ev_src, event_q;

  always_comb begin
    ev_src = rise | fall;
    if (EVT_MODE == EVT_RISE) ev_src = rise;
    if (EVT_MODE == EVT_FALL) ev_src = fall;
  end

  // A pulse arriving while clear is asserted survives (set wins): the pulse
  // shows through event_o now and is captured into event_q for later cycles.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) event_q <= '0;
    else           event_q <= ev_src | (event_q & ~event_clr_i);
  end

  assign event_o = event_q | ev_src;

  // ---------------- LED drive ----------------
  logic [OUT_CH-1:0] led_q;

`ifdef BOARD_IO_PWM_EN
  localparam int               PSW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PSW-1:0]   PS_LAST = PSW'(PRESCALE - 1);

  logic [PSW-1:0]   presc_q;
  logic [PWM_W-1:0] pwm_cnt_q, duty_sh_q;
  logic             presc_tc, pwm_on;

  assign presc_tc = (presc_q == PS_LAST);
  assign pwm_on   = (&duty_sh_q) | (pwm_cnt_q < duty_sh_q);

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      presc_q   <= '0;
      pwm_cnt_q <= '0;
      duty_sh_q <= '1;
    end else if (presc_tc) begin
      presc_q   <= '0;
      pwm_cnt_q <= pwm_cnt_q + PWM_W'(1);
      // Duty only changes at a period boundary so no partial period glitches.
      if (&pwm_cnt_q) duty_sh_q <= led_duty_i;
    end else begin
      presc_q <= presc_q + PSW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) led_q <= '0;
    else           led_q <= led_val_i & {OUT_CH{pwm_on}};
  end
`else
  localparam int    PRESCALE_UNUSED = PRESCALE;
  logic [PWM_W-1:0] duty_unused;
  assign duty_unused = led_duty_i;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) led_q <= '0;
    else           led_q <= led_val_i;
  end
`endif

  assign led_o = led_q;

endmodule

// File: tb/tb_board_io_frontend.sv
`timescale 1ns/1ps
module tb_board_io_frontend;

  localparam int IN_CH = 12, OUT_CH = 8, PWM_W = 4;

  logic              clk = 1'b0;
  logic              arst_n;
  logic [IN_CH-1:0]  in_raw, stable, rise, fall, evt, evt_clr;
  logic [OUT_CH-1:0] led_val, led;
  logic [PWM_W-1:0]  duty;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  board_io_frontend #(
    .IN_CH(IN_CH), .OUT_CH(OUT_CH), .DEB_CYCLES(8), .EVT_MODE(2),
    .PWM_W(PWM_W), .PRESCALE(1)
  ) dut (
    .clk_i       (clk),
    .arst_n_i    (arst_n),
    .in_raw_i    (in_raw),
    .in_stable_o (stable),
    .in_rise_o   (rise),
    .in_fall_o   (fall),
    .event_o     (evt),
    .event_clr_i (evt_clr),
    .led_val_i   (led_val),
    .led_duty_i  (duty),
    .led_o       (led)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc, fc, hc, st_seen;
    logic prev, found;

    arst_n  = 1'b0;
    in_raw  = '1;
    led_val = '1;
    duty    = '1;
    evt_clr = '0;
    #23;
    check("rst_stable", 32'(stable), 0);
    check("rst_rise",   32'(rise | fall), 0);
    check("rst_event",  32'(evt), 0);
    check("rst_led",    32'(led), 0);
    tick();
    check("rst_led_clk", 32'(led), 0);

    // Release: stable appears exactly 2+DEB_CYCLES = 10 cycles later.
    arst_n = 1'b1;
    repeat (9) tick();
    check("rel_stable_9", 32'(stable), 0);
    tick();
    check("rel_stable_10", 32'(stable), 32'hFFF);
    check("rel_rise_10",   32'(rise),   32'hFFF);
    check("rel_event",     32'(evt),    32'hFFF);
    tick();
    check("rel_rise_11",   32'(rise),   0);
    check("rel_led",       32'(led),    32'hFF);

    // Return inputs low and clear events.
    in_raw  = '0;
    evt_clr = '1;
    repeat (12) tick();
    evt_clr = '0;
    tick();
    check("low_stable", 32'(stable), 0);
    check("low_event",  32'(evt),    0);

    // Glitch of 7 cycles on ch3 is rejected.
    rc = 0; st_seen = 0;
    in_raw[3] = 1'b1;
    repeat (7) begin tick(); rc += int'(rise[3]); st_seen += int'(stable[3]); end
    in_raw[3] = 1'b0;
    repeat (15) begin tick(); rc += int'(rise[3]); st_seen += int'(stable[3]); end
    check("glitch_rise",   32'(rc),      0);
    check("glitch_stable", 32'(st_seen), 0);

    // 8-cycle hold is accepted at cycle 10.
    in_raw[3] = 1'b1;
    repeat (9) tick();
    check("hold_stable_9", 32'(stable[3]), 0);
    tick();
    check("hold_stable_10", 32'(stable[3]), 1);
    check("hold_rise_10",   32'(rise[3]),   1);
    tick();
    check("hold_rise_11",   32'(rise[3]),   0);

    // Bounce on ch0: toggling every 3 cycles then held high.
    rc = 0; fc = 0;
    for (int i = 0; i < 10; i++) begin
      in_raw[0] = (i % 2 == 0);
      repeat (3) begin tick(); rc += int'(rise[0]); fc += int'(fall[0]); end
    end
    in_raw[0] = 1'b1;
    repeat (20) begin tick(); rc += int'(rise[0]); fc += int'(fall[0]); end
    check("bounce_rise",   32'(rc), 1);
    check("bounce_fall",   32'(fc), 0);
    check("bounce_stable", 32'(stable[0]), 1);

    // Sticky events on ch1 (both edges).
    evt_clr = '1;
    tick();
    evt_clr = '0;
    tick();
    check("stk_clear_all", 32'(evt), 0);
    in_raw[1] = 1'b1;
    repeat (10) tick();
    check("stk_rise_pulse", 32'(rise[1]), 1);
    check("stk_rise_set",   32'(evt[1]),  1);
    in_raw[1] = 1'b0;
    repeat (9) tick();
    check("stk_pre_fall", 32'(fall[1]), 0);
    evt_clr[1] = 1'b1;
    tick();
    evt_clr[1] = 1'b0;
    check("stk_fall_pulse", 32'(fall[1]), 1);
    check("stk_set_wins",   32'(evt[1]),  1);
    tick();
    check("stk_held",       32'(evt[1]),  1);
    evt_clr[1] = 1'b1;
    tick();
    evt_clr[1] = 1'b0;
    check("stk_cleared",    32'(evt[1]),  0);

    led_val = '0;
    tick();
    check("led_off", 32'(led), 0);

`ifdef BOARD_IO_PWM_EN
    // duty=4 over a 16-step period: 4 high cycles out of 16.
    duty    = 4'd4;
    led_val = 8'h01;
    repeat (20) tick();
    hc = 0;
    repeat (16) begin tick(); hc += int'(led[0]); end
    check("pwm_duty4", 32'(hc), 4);

    // Find the period start (0->1 on led_o[0]), bounded.
    found = 1'b0;
    prev  = led[0];
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (led[0] && !prev) found = 1'b1;
      prev = led[0];
    end
    check("pwm_sync_found", 32'(found), 1);
    repeat (2) tick();
    duty = 4'd15;            // mid-period: old duty still governs steps 3..15
    hc = 0;
    repeat (13) begin tick(); hc += int'(led[0]); end
    check("pwm_old_duty_tail", 32'(hc), 1);
    hc = 0;
    repeat (16) begin tick(); hc += int'(led[0]); end
    check("pwm_full_on", 32'(hc), 16);

    duty    = 4'd0;
    led_val = 8'hA5;
    repeat (40) tick();
    check("pwm_duty0_off", 32'(led), 0);
`else
    led_val = 8'hA5;
    duty    = 4'd0;
    check("led_pre", 32'(led), 0);
    tick();
    check("led_a5", 32'(led), 32'hA5);
    led_val = 8'h5A;
    tick();
    check("led_5a", 32'(led), 32'h5A);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
